sysid_checker: RTL and testbench

- Avalon-MM read master that sits on the same interconnect as the system ID peripheral (control slave, 1-bit word address, 32-bit readdata).
- On start, or automatically once after reset, it reads word 0 (system ID) and then word 1 (timestamp).
- It compares each value with expected parameters and reports pass/fail/timeout flags, so hardware can detect a stale or mismatched FPGA image before the CPU image boots.

---
 rtl/sysid_checker.sv | 127 ++++++++++++
 tb/tb_sysid_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid slave's ID and timestamp words
// and flags a stale or mismatched FPGA image before the CPU boots.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1453208908,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // state  | meaning
  // IDLE   | waiting for start or the one-shot auto launch
  // RD_ID  | reading word 0 (system ID)
  // RD_TS  | reading word 1 (timestamp)
  // FIN    | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_RD_TS, S_FIN} state_t;

  // Abort on the edge where the stall count would reach TIMEOUT_CYCLES.
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_stall_cnt;
  logic        r_auto_armed;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        w_launch;
  logic        w_xfer;
  logic        w_abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    av_read     = 1'b0;
    av_address  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_launch    = 1'b0;
    w_xfer      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || (AUTO_START && r_auto_armed)) begin
          w_launch    = 1'b1;
          w_state_nxt = S_RD_ID;
        end
      end
      S_RD_ID, S_RD_TS: begin
        av_read    = 1'b1;
        av_address = (r_state == S_RD_TS);
        busy       = 1'b1;
        if (!av_waitrequest) begin
          w_xfer      = 1'b1;
          w_state_nxt = (r_state == S_RD_ID) ? S_RD_TS : S_FIN;
        end else if (r_stall_cnt >= STALL_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt  <= '0;
      r_auto_armed <= 1'b1;
      r_id_ok      <= 1'b0;
      r_ts_ok      <= 1'b0;
      r_timeout    <= 1'b0;
      r_id_value   <= '0;
      r_ts_value   <= '0;
    end else begin
      if (w_launch) begin
        r_auto_armed <= 1'b0;
        r_id_ok      <= 1'b0;
        r_ts_ok      <= 1'b0;
        r_timeout    <= 1'b0;
      end
      if (w_xfer && r_state == S_RD_ID) begin
        r_id_value <= av_readdata;
        r_id_ok    <= (av_readdata == EXPECTED_ID);
      end
      if (w_xfer && r_state == S_RD_TS) begin
        r_ts_value <= av_readdata;
        r_ts_ok    <= (av_readdata == EXPECTED_TIMESTAMP);
      end
      if (w_abort) r_timeout <= 1'b1;
      if (!busy || w_xfer || w_abort)
        r_stall_cnt <= '0;
      else if (av_waitrequest && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a zero-latency Avalon slave model with
// programmable per-word stall counts drives the DUT.
module tb_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1453208908;
  localparam logic [31:0] TS_BAD  = 32'd1453208909;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int          errors = 0;
  int          checks = 0;
  int          id_stalls;
  int          ts_stalls;
  logic [31:0] id_mem;
  logic [31:0] ts_mem;
  int          wcnt = 0;
  int          done_cnt = 0;
  int          ts_rd_cnt = 0;
  bit          stab_en = 1'b0;
  logic        p_stall = 1'b0;
  logic        p_addr = 1'b0;
  int          lat;
  int          d0;
  int          t0;

  sysid_checker #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (TS_GOOD),
    .TIMEOUT_CYCLES     (4),
    .AUTO_START         (1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .av_address     (av_address),
    .av_read        (av_read),
    .av_waitrequest (av_waitrequest),
    .av_readdata    (av_readdata),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  always #5 clock = ~clock;

  // Slave: stall the current word for a fixed number of cycles, then complete.
  always @(posedge clock) begin
    if (!av_read || !av_waitrequest) wcnt <= 0;
    else                             wcnt <= wcnt + 1;
  end
  assign av_waitrequest = av_read && (wcnt < (av_address ? ts_stalls : id_stalls));
  assign av_readdata    = av_address ? ts_mem : id_mem;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (av_read === 1'b1 && av_address === 1'b1) ts_rd_cnt++;
    if (stab_en && p_stall) begin
      check("stall_read_stable", {31'd0, av_read}, 32'd1);
      check("stall_addr_stable", {31'd0, av_address}, {31'd0, p_addr});
    end
    p_stall = av_read && av_waitrequest;
    p_addr  = av_address;
  end

  // Counts edges until done is seen; -1 when the budget runs out.
  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    id_stalls = 0;
    ts_stalls = 0;
    id_mem    = 32'd0;
    ts_mem    = TS_GOOD;
    repeat (2) @(negedge clock);
    check("rst_av_read", {31'd0, av_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", ts_value, 32'd0);

    // Auto-start after release, zero wait states.
    reset_n = 1'b1;
    @(negedge clock);
    check("auto_rd_id", {29'd0, av_read, av_address, busy}, 32'b101);
    @(negedge clock);
    check("auto_rd_ts", {29'd0, av_read, av_address, busy}, 32'b111);
    @(negedge clock);
    check("auto_fin", {29'd0, done, busy, av_read}, 32'b100);
    check("auto_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);
    check("auto_ts_value", ts_value, TS_GOOD);
    @(negedge clock);
    check("auto_done_single", {31'd0, done}, 32'd0);

    // Timestamp mismatch.
    ts_mem = TS_BAD;
    d0 = done_cnt;
    pulse_start();
    wait_done(10, lat);
    check("bad_ts_latency", 32'(lat), 32'd2);
    check("bad_ts_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b100);
    check("bad_ts_value", ts_value, TS_BAD);
    repeat (3) @(negedge clock);
    check("bad_ts_one_done", 32'(done_cnt - d0), 32'd1);

    // Three stall cycles on each word; address/read must hold.
    ts_mem = TS_GOOD;
    id_stalls = 3;
    ts_stalls = 3;
    stab_en = 1'b1;
    pulse_start();
    wait_done(20, lat);
    stab_en = 1'b0;
    check("stall_latency", 32'(lat), 32'd8);
    check("stall_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);
    @(negedge clock);

    // Timestamp word stuck in waitrequest: abandoned after 4 stall cycles.
    id_stalls = 0;
    ts_stalls = 1000;
    t0 = ts_rd_cnt;
    pulse_start();
    wait_done(20, lat);
    check("tmo_latency", 32'(lat), 32'd5);
    check("tmo_read_cycles", 32'(ts_rd_cnt - t0), 32'd4);
    check("tmo_av_read", {31'd0, av_read}, 32'd0);
    check("tmo_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b101);
    check("tmo_ts_value_held", ts_value, TS_GOOD);
    @(negedge clock);

    // start held through RD_ID, RD_TS and FIN must not queue a second run.
    ts_stalls = 0;
    d0 = done_cnt;
    start = 1'b1;
    repeat (4) @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(negedge clock);
    check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_start_idle", {31'd0, busy}, 32'd0);
    check("busy_start_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);

    // Reset in the middle of a timestamp stall, then auto rerun.
    ts_stalls = 3;
    id_mem = 32'd0;
    pulse_start();
    repeat (2) @(posedge clock);
    #1;
    check("mid_pre_read", {30'd0, av_read, av_address}, 32'b11);
    reset_n = 1'b0;
    #1;
    check("mid_rst_av_read", {31'd0, av_read}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    check("mid_rst_values", id_value | ts_value, 32'd0);
    ts_stalls = 0;
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(10, lat);
    check("rerun_latency", 32'(lat), 32'd3);
    check("rerun_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);
    check("rerun_ts_value", ts_value, TS_GOOD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
